// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: registered immediate extender with valid/ready handshake and 2-entry skid buffer
// Ports: clk/rstn (async active-low), in_valid/in_ready/in_imm/in_op/in_tag (producer side),
//        out_valid/out_ready/out_data/out_tag/out_bad_op (consumer side), flush (sync drop of all
//        held beats and the current input), occupancy (beats held, 0..2).
module imm_ext_pipe #(
  parameter int IMM_W     = 16,
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 5,
  parameter int SHAMT_LSB = 6,
  parameter int SHAMT_W   = 5
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [2:0]        in_op,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_bad_op,
  input  logic              flush,
  output logic [1:0]        occupancy
);
  logic [DATA_W-1:0] sx, ext;
  logic              bad, acc, drn;
  logic              ov_q, ov_d, ob_q, ob_d, sv_q, sv_d, sb_q, sb_d;
  logic [DATA_W-1:0] od_q, od_d, sd_q, sd_d;
  logic [TAG_W-1:0]  ot_q, ot_d, st_q, st_d;
  always_comb begin
    sx  = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
    bad = in_op > 3'd4;
    ext = in_op == 3'd0 ? {{(DATA_W-IMM_W){1'b0}}, in_imm} :
          in_op == 3'd1 ? sx :
          in_op == 3'd2 ? {in_imm, {(DATA_W-IMM_W){1'b0}}} :
          in_op == 3'd3 ? {sx[DATA_W-3:0], 2'b00} :
          in_op == 3'd4 ? {{(DATA_W-SHAMT_W){1'b0}}, in_imm[SHAMT_LSB +: SHAMT_W]} : '0;
  end
  // in_ready comes straight from the skid flop, so out_ready never reaches it combinationally
  assign in_ready  = ~sv_q;
  assign acc       = in_valid & in_ready & ~flush;
  assign drn       = ~ov_q | out_ready;
  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_tag   = ot_q;
  assign out_bad_op = ob_q;
  assign occupancy = {1'b0, ov_q} + {1'b0, sv_q};
  always_comb begin
    ov_d = ov_q; od_d = od_q; ot_d = ot_q; ob_d = ob_q;
    sv_d = sv_q; sd_d = sd_q; st_d = st_q; sb_d = sb_q;
    if (flush) begin
      ov_d = 1'b0;
      sv_d = 1'b0;
    end else if (sv_q && drn) begin
      ov_d = 1'b1; od_d = sd_q; ot_d = st_q; ob_d = sb_q;
      sv_d = 1'b0;
    end else if (acc && drn) begin
      ov_d = 1'b1; od_d = ext; ot_d = in_tag; ob_d = bad;
    end else if (acc) begin
      sv_d = 1'b1; sd_d = ext; st_d = in_tag; sb_d = bad;
    end else if (ov_q && out_ready) begin
      ov_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ov_q <= 1'b0; od_q <= '0; ot_q <= '0; ob_q <= 1'b0;
      sv_q <= 1'b0; sd_q <= '0; st_q <= '0; sb_q <= 1'b0;
    end else begin
      ov_q <= ov_d; od_q <= od_d; ot_q <= ot_d; ob_q <= ob_d;
      sv_q <= sv_d; sd_q <= sd_d; st_q <= st_d; sb_q <= sb_d;
    end
  end
endmodule

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
- Registered, parametrised immediate-extension stage for the pipelined MIPS datapath, placed between ID-stage decode and the ID/EX operand mux.
- Generalises the single-cycle extender in three ways: IMM_W/DATA_W widths, additional modes (branch-offset shift, shamt extraction), and a tag passthrough.
- Adds a valid/ready handshake with a 2-entry skid buffer, so in_ready is a registered signal and back-pressure never breaks throughput.

Parameters:
- IMM_W, 16, immediate input width
- DATA_W, 32, extended output width; requirement DATA_W >= IMM_W+2
- TAG_W, 5, sideband tag width (for example, destination register), carried unchanged
- SHAMT_LSB, 6, LSB position of the shamt field inside imm
- SHAMT_W, 5, shamt field width

Ports:
- clk  in  1  rising-edge clock
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept a beat (registered)
- in_imm  in  IMM_W  raw immediate
- in_op  in  3  extension mode
- in_tag  in  TAG_W  sideband
- out_valid  out  1  output beat valid
- out_ready  in  1  consumer accepts
- out_data  out  DATA_W  extended value
- out_tag  out  TAG_W  tag of the beat
- out_bad_op  out  1  beat carried a reserved op
- flush  in  1  synchronous pipeline flush
- occupancy  out  2  beats held (0..2)

Behaviour:
- Mode encoding (in_op):
  - 0 ZERO: {0, imm}
  - 1 SIGNED: sign-extend imm[IMM_W-1]
  - 2 HIGHPOS: {imm, (DATA_W-IMM_W) zeros}
  - 3 SIGNED_SL2: sign-extended value shifted left 2, truncated to DATA_W
  - 4 SHAMT: zero-extend imm[SHAMT_LSB+SHAMT_W-1:SHAMT_LSB]
  - 5..7 reserved: data = 0, bad_op = 1. Output is always defined; no hold behaviour.
- Extension is combinational on input. The result is registered together with tag and bad_op.
- Accept: acc = in_valid & in_ready & ~flush.
- Drain: drn = ~out_valid | out_ready.
- Storage: output register O (out_*) and skid register S (s_valid, s_data, s_tag, s_bad).
- in_ready = ~s_valid (from flop, no combinational path from out_ready).
- Per-clock update, in priority order:
  1. flush: out_valid <= 0, s_valid <= 0; the input beat in this cycle is dropped. Data registers are don't-care.
  2. s_valid & drn: O <= S, out_valid <= 1, s_valid <= 0. acc is impossible here (in_ready = 0).
  3. acc & drn: O <= new beat, out_valid <= 1.
  4. acc & ~drn: S <= new beat, s_valid <= 1; O holds.
  5. ~acc & out_valid & out_ready: out_valid <= 0.
  6. Otherwise hold.
- Latency: 1 clock from accepted beat to out_valid when unblocked.
- Throughput: 1 beat/clock with out_ready held high.
- Ordering: strict FIFO; beats are never dropped or duplicated except on flush.
- While out_valid & ~out_ready, out_data, out_tag and out_bad_op are stable.
- occupancy = out_valid + s_valid.
- Reset (async assert, sync-to-clk release is the integrator's concern):
  - out_valid = 0, s_valid = 0
  - out_data = 0, out_tag = 0, out_bad_op = 0
  - in_ready = 1, occupancy = 0
- Reset mid-stream discards all held beats.
- Flush while full (occupancy 2): next cycle occupancy 0, in_ready 1.
- in_valid without in_ready: the beat is not taken. The producer must hold it; the stage keeps no memory of it.

Test Plan:
- Modes, IMM_W=16, DATA_W=32, out_ready=1, imm=16'h8004:
  - op0 -> 32'h00008004
  - op1 -> 32'hFFFF8004
  - op2 -> 32'h80040000
  - op3 -> 32'hFFFE0010
  - op4 -> 32'h00000000 (imm[10:6]=0)
  - imm=16'h07C0 op4 -> 32'h0000001F
  - op6 -> data 0, bad_op 1
  - each result appears exactly 1 clk after accept.
- Stream of 8 beats (tags 0..7), out_ready=1 throughout -> 8 consecutive out_valid cycles, tags in order, in_ready stays 1.
- Back-pressure: out_ready=0 after beat A is accepted; send B -> occupancy 2, in_ready 0 next clk, C held off. Raise out_ready -> A, B, C emerge in order with no gap; out_data stable while stalled.
- Flush at occupancy 2 with in_valid=1 in the same clk -> next clk out_valid 0, occupancy 0, in_ready 1; the flushed-cycle input never appears.
- rstn pulled low mid-stream (occupancy 1) -> all outputs at reset values immediately without a clock edge. After release, a fresh beat op1 imm=16'h0001 -> 32'h00000001.
